// File: rtl/dot_product_engine.sv
// Multi-cycle dot product engine: captures two NDATA-element vectors, then
// accumulates LANES products per cycle over STEPS cycles, then holds the result
// until the consumer takes it.

module dpe_lane #(
  parameter int NBITS = 8,
  parameter int ACCW  = 18
) (
  input  logic [NBITS-1:0] a_i,
  input  logic [NBITS-1:0] b_i,
  input  logic             sgn_i,
  output logic [ACCW-1:0]  prod_o
);
  logic [ACCW-1:0] a_x, b_x;

  // Extend to accumulator width first; the truncated ACCW-bit product is then
  // exact modulo 2^ACCW for both signed and unsigned operands.
  assign a_x    = {{(ACCW-NBITS){sgn_i & a_i[NBITS-1]}}, a_i};
  assign b_x    = {{(ACCW-NBITS){sgn_i & b_i[NBITS-1]}}, b_i};
  assign prod_o = a_x * b_x;
endmodule

module dot_product_engine #(
  parameter int  NDATA = 4,
  parameter int  NBITS = 8,
  parameter int  LANES = 1,
  localparam int ACCW  = 2*NBITS + $clog2(NDATA),
  localparam int STEPS = NDATA / LANES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBITS*NDATA-1:0] a_vec,
  input  logic [NBITS*NDATA-1:0] b_vec,
  input  logic                   signed_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACCW-1:0]        result,
  output logic                   busy
);
  localparam int SW = $clog2(STEPS + 1);
  localparam int VW = NBITS * NDATA;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                      state_q, state_d;
  logic [VW-1:0]               a_q, a_d, b_q, b_d;
  logic                        sgn_q, sgn_d;
  logic [ACCW-1:0]             acc_q, acc_d;
  logic [SW-1:0]               step_q, step_d;
  logic [LANES-1:0][ACCW-1:0]  prod;
  logic [ACCW-1:0]             lane_sum;

  // Operand registers shift down by LANES elements per RUN cycle, so lane l
  // always sees the next unconsumed element at the bottom of the vector.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dpe_lane #(.NBITS(NBITS), .ACCW(ACCW)) u_lane (
      .a_i    (a_q[l*NBITS +: NBITS]),
      .b_i    (b_q[l*NBITS +: NBITS]),
      .sgn_i  (sgn_q),
      .prod_o (prod[l])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + prod[l];
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    acc_d     = acc_q;
    step_d    = step_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a_vec;
          b_d     = b_vec;
          sgn_d   = signed_mode;
          acc_d   = '0;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_q + lane_sum;
        a_d    = a_q >> (LANES*NBITS);
        b_d    = b_q >> (LANES*NBITS);
        step_d = step_q + SW'(1);
        if (step_q == SW'(STEPS-1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign result = acc_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// Directed + random checks of dot_product_engine against an integer model;
// a second LANES=2 instance covers the multi-lane path.

module tb_dot_product_engine;
  localparam int NB    = 8;
  localparam int ND    = 4;
  localparam int ACCW  = 2*NB + $clog2(ND);
  localparam int STEPS = 4;

  logic            clk = 1'b0;
  logic            reset, in_valid, out_ready, signed_mode;
  logic [NB*ND-1:0] a_vec, b_vec;
  logic            in_ready, out_valid, busy;
  logic [ACCW-1:0] result;
  logic            in_valid2, out_ready2;
  logic            in_ready2, out_valid2, busy2;
  logic [ACCW-1:0] result2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dot_product_engine #(.NDATA(ND), .NBITS(NB), .LANES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  dot_product_engine #(.NDATA(ND), .NBITS(NB), .LANES(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_vec(a_vec), .b_vec(b_vec), .signed_mode(signed_mode),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .busy(busy2)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
    logic [31:0] v;
    v = {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    return v;
  endfunction

  // Plain integer dot product, reduced to ACCW bits.
  function automatic logic [ACCW-1:0] ref_dot(input logic [31:0] av, input logic [31:0] bv, input bit sgn);
    longint s, x, y;
    s = 0;
    for (int i = 0; i < ND; i++) begin
      x = sgn ? longint'($signed(av[i*8 +: 8])) : longint'(av[i*8 +: 8]);
      y = sgn ? longint'($signed(bv[i*8 +: 8])) : longint'(bv[i*8 +: 8]);
      s += x * y;
    end
    return s[ACCW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input bit sgn, input int hold);
    logic [ACCW-1:0] exp;
    int n;
    exp = ref_dot(av, bv, sgn);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_ready"}, in_ready, 1);
    a_vec = av; b_vec = bv; signed_mode = sgn; in_valid = 1'b1;
    tick();
    // Scramble inputs while the operation is in flight; they must be ignored.
    in_valid = 1'b0; a_vec = $urandom; b_vec = $urandom; signed_mode = ~sgn;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_inrdy_run"}, in_ready, 0);
    for (int k = 1; k < STEPS; k++) begin
      chk({tag, "_early_valid"}, out_valid, 0);
      in_valid = 1'($urandom); a_vec = $urandom;
      tick();
    end
    chk({tag, "_early_valid"}, out_valid, 0);
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, result, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); a_vec = $urandom; b_vec = $urandom; signed_mode = 1'($urandom);
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_result"}, result, exp);
      chk({tag, "_hold_inrdy"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_inrdy"}, in_ready, 1);
    chk({tag, "_post_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] av, bv;
    logic [ACCW-1:0] exp;
    int last, rises;
    bit seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; signed_mode = 1'b0;
    a_vec = '0; b_vec = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    tick(); tick();
    chk("rst_inrdy", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    reset = 1'b0;

    out_ready = 1'b1;
    tick();
    chk("idle_oready_valid", out_valid, 0);
    chk("idle_oready_busy", busy, 0);
    out_ready = 1'b0;

    do_req("u_basic", pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 0);
    chk("u_basic_const", result, 70);
    do_req("s_80", pack4(128, 128, 128, 128), pack4(128, 128, 128, 128), 1'b1, 0);
    chk("s_80_const", result, 18'h10000);
    do_req("u_ff", pack4(255, 255, 255, 255), pack4(255, 255, 255, 255), 1'b0, 1);
    chk("u_ff_const", result, 18'h3F804);
    do_req("s_mixed", pack4(-1, 2, -3, 4), pack4(5, -6, 7, 8), 1'b1, 0);
    chk("s_mixed_const", result, 18'h3FFFA);
    do_req("bp", pack4(9, 200, 33, 7), pack4(250, 3, 17, 99), 1'b0, 5);

    for (int r = 0; r < 16; r++)
      do_req("rand", $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));

    // Back-to-back requests with out_ready held high.
    av = $urandom; bv = $urandom;
    exp = ref_dot(av, bv, 1'b1);
    a_vec = av; b_vec = bv; signed_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    last = -1; rises = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid) begin
        chk("tput_result", result, exp);
        if (last >= 0) chk("tput_period", 64'(c - last), STEPS + 2);
        last = c; rises++;
      end
    end
    chk("tput_count", 64'(rises >= 4), 1);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    out_ready = 1'b0;
    chk("tput_idle", busy, 0);

    // Abort in the second RUN cycle.
    a_vec = pack4(10, 20, 30, 40); b_vec = pack4(1, 2, 3, 4); signed_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("abort_running", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_inrdy", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_result", result, 0);
    seen = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin tick(); seen |= out_valid; end
    out_ready = 1'b0;
    chk("abort_no_valid", seen, 0);
    do_req("after_abort", pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0, 0);
    chk("after_abort_const", result, 8);

    // LANES=2 instance: two RUN cycles.
    a_vec = pack4(1, 2, 3, 4); b_vec = pack4(5, 6, 7, 8); signed_mode = 1'b0; in_valid2 = 1'b1;
    chk("l2_ready", in_ready2, 1);
    tick();
    in_valid2 = 1'b0; a_vec = $urandom; b_vec = $urandom;
    chk("l2_busy", busy2, 1);
    chk("l2_early0", out_valid2, 0);
    tick();
    chk("l2_early1", out_valid2, 0);
    tick();
    chk("l2_valid", out_valid2, 1);
    chk("l2_result", result2, 70);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    chk("l2_post_valid", out_valid2, 0);
    chk("l2_post_inrdy", in_ready2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter NDATA, default 4, number of elements per vector (>=2).
REQ-002 SHALL have parameter NBITS, default 8, element width in bits.
REQ-003 SHALL have parameter LANES, default 1, products summed per cycle; NDATA divisible by LANES.
REQ-004 SHALL define derived constants ACCW = 2*NBITS + clog2(NDATA) and STEPS = NDATA/LANES.
REQ-005 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have in_valid  input  1  request: vectors and mode present.
REQ-008 SHALL have in_ready  output  1  engine can accept a request.
REQ-009 SHALL have a_vec  input  NBITS*NDATA  element i at bits [i*NBITS +: NBITS].
REQ-010 SHALL have b_vec  input  NBITS*NDATA  same packing as a_vec.
REQ-011 SHALL have signed_mode  input  1  1 = two's-complement elements, 0 = unsigned.
REQ-012 SHALL have out_valid  output  1  result holds a completed dot product.
REQ-013 SHALL have out_ready  input  1  consumer takes the result.
REQ-014 SHALL have result  output  ACCW  sum over i of a[i]*b[i].
REQ-015 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement three states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid=1, SHALL register a_vec, b_vec and signed_mode, clear the accumulator and the step counter, and go to RUN.
REQ-018 RUN: in_ready=0; each cycle SHALL add the sum of LANES products for the next unconsumed elements, in ascending index order, to the accumulator and increment the step counter.
REQ-019 After STEPS RUN cycles, SHALL go to DONE, with result equal to the full dot product.
REQ-020 out_valid SHALL rise exactly STEPS cycles after the accepting edge.
REQ-021 DONE: out_valid=1; result SHALL stay stable until the handshake completes.
REQ-022 DONE with out_ready=1 SHALL complete the handshake and go to IDLE; in_ready returns to 1 in the next cycle, and no request is accepted in the same cycle.
REQ-023 While in RUN or DONE, in_valid, a_vec, b_vec and signed_mode SHALL be ignored; changes to them SHALL NOT affect the operation in progress.
REQ-024 signed_mode=1: operands SHALL be sign-extended; products and sums use two's complement at ACCW bits.
REQ-025 signed_mode=0: operands SHALL be zero-extended.
REQ-026 ACCW SHALL hold every possible result in either mode; no overflow or saturation logic.
REQ-027 out_ready while out_valid=0 SHALL have no effect.
REQ-028 Throughput SHALL be one request per STEPS+2 cycles when out_ready is held at 1.

Reset
REQ-029 reset=1 SHALL, at the next edge, force IDLE, with out_valid=0, busy=0, in_ready=1, result=0, and the accumulator and step counter cleared.
REQ-030 reset SHALL take priority over all other inputs; reset during RUN or DONE SHALL abort the operation, and that result SHALL never be presented.
REQ-031 The first request after reset deasserts SHALL be accepted normally.

Verification
REQ-032 Defaults, unsigned: A={1,2,3,4}, B={5,6,7,8} -> out_valid 4 cycles after accept, result=70.
REQ-033 Defaults, signed: all elements 0x80 in A and B -> result=65536 (0x10000); unsigned, all elements 0xFF -> result=260100 (0x3F804).
REQ-034 Signed mixed: A={-1,2,-3,4}, B={5,-6,7,8} -> result = -5-12-21+32 = -6 = 0x3FFFA (18 bits).
REQ-035 Backpressure: out_ready held 0 for 5 cycles in DONE, with new in_valid and vectors toggling -> result unchanged, in_ready=0, single handshake on out_ready=1.
REQ-036 LANES=2 with the values of REQ-032 -> result=70, out_valid 2 cycles after accept.
REQ-037 Reset asserted in the 2nd RUN cycle -> next cycle IDLE, result=0, out_valid never pulses; the following request (A={1,1,1,1}, B={2,2,2,2}) returns 8.
